rob_ctrl: RTL and testbench

Reorder-buffer controller for the out-of-order core. Allocates ROB slots to decoded instructions in program order and captures result writebacks from execution units by slot number. Retires completed entries in order to the register file, and silently discards entries from a squashed instruction stream. Sits between decode/issue (allocation), the execution units (writeback) and the register file (commit); its entry layout matches the shared `rob_entry_t`.

---
 rtl/rob_ctrl_pkg.sv | 26 ++
 rtl/rob_ptr.sv | 42 ++++
 rtl/rob_ctrl.sv | 103 ++++++++++
 tb/tb_rob_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared reorder-buffer types and widths.
package rob_ctrl_pkg;

  localparam int ROB_SLOT_W = 7;
  localparam int REG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int COUNT_W    = 8;

  // Architectural entry layout shared with the rest of the core.
  typedef struct packed {
    logic              pc_valid;       // live flag, cleared by flush
    logic [REG_W-1:0]  dest_reg;
    logic              dest_reg_valid;
    logic              stream;
    logic [DATA_W-1:0] result_hi;
    logic [DATA_W-1:0] result_lo;
  } rob_entry_t;

  // Controller-side entry: architectural fields plus bookkeeping.
  typedef struct packed {
    rob_entry_t ent;
    logic       busy;                  // slot allocated
    logic       done;                  // result written back
  } rob_ctrl_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Head/tail pointers with wrap bit and the occupancy flags derived from them.
module rob_ptr
  import rob_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inc_head,
  input  logic               inc_tail,
  output logic [PTR_W-1:0]   head,
  output logic [PTR_W-1:0]   tail,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] occ;

  // Pointers advance by one; the MSB toggles naturally on wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (inc_head) head <= head + PTR_W'(1);
      if (inc_tail) tail <= tail + PTR_W'(1);
    end
  end

  // Occupancy: equal pointers mean empty, equal index with opposite wrap means full.
  always_comb begin
    occ   = tail - head;
    empty = (head == tail);
    full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    count = COUNT_W'(occ);
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, by-slot writeback,
// stream-based squash and in-order retire to the register file.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alloc_req,
  input  logic [REG_W-1:0]      alloc_dest_reg,
  input  logic                  alloc_dest_reg_valid,
  input  logic                  alloc_stream,
  output logic                  alloc_gnt,
  output logic [ROB_SLOT_W-1:0] alloc_slot,
  input  logic                  wr_valid,
  input  logic [ROB_SLOT_W-1:0] wr_slot,
  input  logic [DATA_W-1:0]     wr_result_hi,
  input  logic [DATA_W-1:0]     wr_result_lo,
  input  logic                  flush,
  input  logic                  flush_stream,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic [REG_W-1:0]      commit_dest_reg,
  output logic                  commit_dest_reg_valid,
  output logic [DATA_W-1:0]     commit_result_hi,
  output logic [DATA_W-1:0]     commit_result_lo,
  output logic [COUNT_W-1:0]    count,
  output logic                  full,
  output logic                  empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  rob_ctrl_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx, wr_idx;
  logic             wr_hit, retire, auto_retire;
  rob_ctrl_entry_t  head_e;

  rob_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc_head (retire),
    .inc_tail (alloc_gnt),
    .head     (head),
    .tail     (tail),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Allocation grant, writeback qualification and head retire decision.
  always_comb begin
    head_idx  = head[IDX_W-1:0];
    tail_idx  = tail[IDX_W-1:0];
    wr_idx    = wr_slot[IDX_W-1:0];
    alloc_gnt = alloc_req && !full;
    alloc_slot = ROB_SLOT_W'(tail_idx);
    // Out-of-range slots are dropped before indexing so they cannot alias.
    wr_hit    = wr_valid && ({1'b0, wr_slot} < COUNT_W'(DEPTH)) && mem[wr_idx].busy;
    head_e    = mem[head_idx];
    commit_valid          = head_e.busy && head_e.ent.pc_valid && head_e.done;
    auto_retire           = head_e.busy && !head_e.ent.pc_valid;
    retire                = (commit_valid && commit_ready) || auto_retire;
    commit_dest_reg       = head_e.ent.dest_reg;
    commit_dest_reg_valid = head_e.ent.dest_reg_valid;
    commit_result_hi      = head_e.ent.result_hi;
    commit_result_lo      = head_e.ent.result_lo;
  end

  // Per-entry update. Alloc and retire never target the same slot (full
  // blocks alloc, empty has nothing to retire), and a write in the alloc
  // cycle misses because busy is still the pre-edge value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_gnt && (IDX_W'(i) == tail_idx)) begin
          mem[i].busy               <= 1'b1;
          mem[i].done               <= 1'b0;
          mem[i].ent.pc_valid       <= !(flush && (alloc_stream != flush_stream));
          mem[i].ent.dest_reg       <= alloc_dest_reg;
          mem[i].ent.dest_reg_valid <= alloc_dest_reg_valid;
          mem[i].ent.stream         <= alloc_stream;
        end else begin
          if (wr_hit && (IDX_W'(i) == wr_idx)) begin
            mem[i].done          <= 1'b1;
            mem[i].ent.result_hi <= wr_result_hi;
            mem[i].ent.result_lo <= wr_result_lo;
          end
          if (flush && mem[i].busy && (mem[i].ent.stream != flush_stream))
            mem[i].ent.pc_valid <= 1'b0;
          if (retire && (IDX_W'(i) == head_idx))
            mem[i].busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl with immediate-assertion checks.
module tb_rob_ctrl;
  import rob_ctrl_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  alloc_req;
  logic [REG_W-1:0]      alloc_dest_reg;
  logic                  alloc_dest_reg_valid;
  logic                  alloc_stream;
  logic                  alloc_gnt;
  logic [ROB_SLOT_W-1:0] alloc_slot;
  logic                  wr_valid;
  logic [ROB_SLOT_W-1:0] wr_slot;
  logic [DATA_W-1:0]     wr_result_hi, wr_result_lo;
  logic                  flush, flush_stream;
  logic                  commit_valid, commit_ready;
  logic [REG_W-1:0]      commit_dest_reg;
  logic                  commit_dest_reg_valid;
  logic [DATA_W-1:0]     commit_result_hi, commit_result_lo;
  logic [COUNT_W-1:0]    count;
  logic                  full, empty;

  int checks = 0;
  int errors = 0;

  rob_ctrl #(.DEPTH(32)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .alloc_req             (alloc_req),
    .alloc_dest_reg        (alloc_dest_reg),
    .alloc_dest_reg_valid  (alloc_dest_reg_valid),
    .alloc_stream          (alloc_stream),
    .alloc_gnt             (alloc_gnt),
    .alloc_slot            (alloc_slot),
    .wr_valid              (wr_valid),
    .wr_slot               (wr_slot),
    .wr_result_hi          (wr_result_hi),
    .wr_result_lo          (wr_result_lo),
    .flush                 (flush),
    .flush_stream          (flush_stream),
    .commit_valid          (commit_valid),
    .commit_ready          (commit_ready),
    .commit_dest_reg       (commit_dest_reg),
    .commit_dest_reg_valid (commit_dest_reg_valid),
    .commit_result_hi      (commit_result_hi),
    .commit_result_lo      (commit_result_lo),
    .count                 (count),
    .full                  (full),
    .empty                 (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    alloc_req = 0; alloc_dest_reg = '0; alloc_dest_reg_valid = 0; alloc_stream = 0;
    wr_valid = 0; wr_slot = '0; wr_result_hi = '0; wr_result_lo = '0;
    flush = 0; flush_stream = 0; commit_ready = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
  endtask

  task automatic alloc(input logic [4:0] dst, input logic strm);
    alloc_req = 1; alloc_dest_reg = dst; alloc_dest_reg_valid = 1; alloc_stream = strm;
  endtask

  task automatic wr(input logic [6:0] slot, input logic [31:0] hi, input logic [31:0] lo);
    wr_valid = 1; wr_slot = slot; wr_result_hi = hi; wr_result_lo = lo;
  endtask

  initial begin
    reset_n = 1;
    idle_inputs();
    // ---- reset state ----
    reset_n = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_cv", commit_valid, 0);
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_slot", alloc_slot, 0);
    chk("rst_lo", commit_result_lo, 0);
    chk("rst_hi", commit_result_hi, 0);
    chk("rst_dst", commit_dest_reg, 0);
    step();
    reset_n = 1;

    // ---- fill ----
    for (int i = 0; i < 32; i++) begin
      alloc(5'(i), 0);
      #1;
      chk("fill_gnt", alloc_gnt, 1);
      chk("fill_slot", alloc_slot, 64'(i));
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);
    chk("fill_gnt33", alloc_gnt, 0);
    step();
    chk("fill_count_hold", count, 32);

    // ---- out-of-order writeback ----
    do_reset();
    commit_ready = 1;
    for (int i = 0; i < 3; i++) begin
      alloc(5'(i + 1), 0);
      step();
    end
    alloc_req = 0;
    wr(2, 32'hA2, 32'h22);
    #1; chk("ooo_cv_w2", commit_valid, 0);
    step();
    wr(0, 32'hA0, 32'h00);
    #1; chk("ooo_cv_w0", commit_valid, 0);
    step();
    wr_valid = 0; commit_ready = 0;
    #1;
    chk("ooo_stall_cv", commit_valid, 1);
    chk("ooo_stall_dst", commit_dest_reg, 1);
    chk("ooo_stall_hi", commit_result_hi, 32'hA0);
    step();
    wr(1, 32'hA1, 32'h11);
    #1;
    chk("ooo_stall2_cv", commit_valid, 1);
    chk("ooo_stall2_hi", commit_result_hi, 32'hA0);
    chk("ooo_stall2_lo", commit_result_lo, 32'h00);
    chk("ooo_stall_count", count, 3);
    step();
    wr_valid = 0; commit_ready = 1;
    #1;
    chk("ooo_c0_cv", commit_valid, 1);
    chk("ooo_c0_dst", commit_dest_reg, 1);
    step();
    chk("ooo_c1_cv", commit_valid, 1);
    chk("ooo_c1_dst", commit_dest_reg, 2);
    chk("ooo_c1_lo", commit_result_lo, 32'h11);
    step();
    chk("ooo_c2_cv", commit_valid, 1);
    chk("ooo_c2_dst", commit_dest_reg, 3);
    chk("ooo_c2_lo", commit_result_lo, 32'h22);
    step();
    chk("ooo_end_cv", commit_valid, 0);
    chk("ooo_end_empty", empty, 1);

    // ---- flush ----
    do_reset();
    commit_ready = 1;
    alloc(4, 0); step();
    alloc(5, 0); step();
    alloc(6, 1); step();
    alloc(7, 1); step();
    alloc_req = 0; flush = 1; flush_stream = 1;
    #1;
    chk("fl_count0", count, 4);
    chk("fl_cv0", commit_valid, 0);
    step();
    flush = 0;
    wr(0, 0, 32'h0C);
    #1;
    chk("fl_auto0_cv", commit_valid, 0);
    chk("fl_auto0_count", count, 4);
    step();
    wr(1, 0, 32'h1C);
    #1;
    chk("fl_auto1_cv", commit_valid, 0);
    chk("fl_auto1_count", count, 3);
    step();
    wr(2, 0, 32'h2C);
    #1;
    chk("fl_wait2_cv", commit_valid, 0);
    chk("fl_wait2_count", count, 2);
    step();
    wr(3, 0, 32'h3C);
    #1;
    chk("fl_c2_cv", commit_valid, 1);
    chk("fl_c2_dst", commit_dest_reg, 6);
    chk("fl_c2_lo", commit_result_lo, 32'h2C);
    step();
    wr_valid = 0;
    #1;
    chk("fl_c3_cv", commit_valid, 1);
    chk("fl_c3_dst", commit_dest_reg, 7);
    chk("fl_c3_lo", commit_result_lo, 32'h3C);
    chk("fl_c3_count", count, 1);
    step();
    chk("fl_end_empty", empty, 1);

    // ---- wrap-around ----
    do_reset();
    for (int i = 0; i < 40; i++) begin
      alloc(5'(i % 32), 0); commit_ready = 0;
      #1;
      chk("wrap_gnt", alloc_gnt, 1);
      chk("wrap_slot", alloc_slot, 64'(i % 32));
      step();
      alloc_req = 0;
      wr(7'(i % 32), 32'(i), 32'(i));
      #1;
      chk("wrap_count_le", 64'(count <= 32), 1);
      step();
      wr_valid = 0; commit_ready = 1;
      #1;
      chk("wrap_cv", commit_valid, 1);
      chk("wrap_dst", commit_dest_reg, 64'(i % 32));
      chk("wrap_lo", commit_result_lo, 64'(i));
      step();
    end
    chk("wrap_empty", empty, 1);

    // ---- illegal writes ----
    do_reset();
    commit_ready = 1;
    wr(3, 0, 32'hBAD);
    #1; chk("ill_pre_count", count, 0);
    step();
    alloc(10, 0); wr(0, 0, 32'hBAD);
    step();
    wr_valid = 0;
    for (int i = 1; i < 5; i++) begin
      alloc(5'(10 + i), 0);
      step();
    end
    alloc_req = 0;
    wr(100, 0, 32'hBAD);
    #1;
    chk("ill_cv_same_cycle", commit_valid, 0);
    chk("ill_count5", count, 5);
    step();
    wr(0, 0, 32'h10);
    #1;
    chk("ill_count_after", count, 5);
    chk("ill_cv_after", commit_valid, 0);
    step();
    wr(1, 0, 32'h11);
    #1;
    chk("ill_c0_cv", commit_valid, 1);
    chk("ill_c0_lo", commit_result_lo, 32'h10);
    step();
    wr(2, 0, 32'h12);
    #1;
    chk("ill_c1_lo", commit_result_lo, 32'h11);
    step();
    wr_valid = 0;
    #1;
    chk("ill_c2_lo", commit_result_lo, 32'h12);
    step();
    wr(3, 0, 32'h03);
    #1;
    chk("ill_pre_wr_ignored", commit_valid, 0);
    step();
    wr(3, 0, 32'h13); commit_ready = 0;
    #1;
    chk("ill_c3_cv", commit_valid, 1);
    chk("ill_c3_first", commit_result_lo, 32'h03);
    step();
    wr_valid = 0; commit_ready = 1;
    #1;
    chk("ill_c3_overwrite", commit_result_lo, 32'h13);
    step();
    chk("ill_slot100_ignored", commit_valid, 0);
    chk("ill_final_count", count, 1);

    // ---- async reset mid-stream ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc(5'(i + 1), 0);
      step();
    end
    alloc_req = 0;
    wr(0, 32'h55, 32'h66);
    step();
    wr_valid = 0;
    #1;
    chk("ar_count10", count, 10);
    chk("ar_cv_pre", commit_valid, 1);
    reset_n = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_cv", commit_valid, 0);
    chk("ar_gnt", alloc_gnt, 0);
    chk("ar_slot", alloc_slot, 0);
    chk("ar_lo", commit_result_lo, 0);
    chk("ar_hi", commit_result_hi, 0);
    step();
    reset_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
